// File: rtl/hazard_defs.sv
// Shared definitions for the hazard/forwarding controller: forward-select
// encodings, controller FSM states and a width helper.
package hazard_defs;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // Bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Single-source forward select: compares one ID source register against
// the destinations of the instructions in EX and MEM. EX wins on a tie.
module fwd_sel_calc
    import hazard_defs::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic          used,
    input  logic          ex_regwrite,
    input  logic [AW-1:0] ex_rd,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] mem_rd,
    output logic [1:0]    sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = used & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == src);
    assign mem_hit = used & mem_regwrite & (mem_rd != '0) & (mem_rd == src);

    // Priority select: nearest producer first, register file otherwise.
    always_comb begin
        sel = FWD_REGFILE;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: load-use bubble, memory-wait freeze,
// registered EX forward selects, stall counters and a sticky timeout flag.
module hazard_fwd_ctrl
    import hazard_defs::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int AW          = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]    id_src_used,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [AW-1:0]         ex_rd,
    input  logic                  mem_regwrite,
    input  logic [AW-1:0]         mem_rd,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  freeze,
    output logic [NUM_SRC*2-1:0]  fwd_sel,
    output logic [CNT_W-1:0]      lu_stall_cnt,
    output logic [CNT_W-1:0]      mem_stall_cnt,
    output logic                  mem_timeout
);

    localparam int              WAIT_W   = clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [NUM_SRC*2-1:0] fwd_pre;
    logic [NUM_SRC-1:0]   lu_hit;
    logic                 lu;

    logic [NUM_SRC*2-1:0] fwd_sel_reg;
    logic [CNT_W-1:0]     lu_cnt_reg;
    logic [CNT_W-1:0]     mem_cnt_reg;
    logic                 timeout_reg;
    logic                 timeout_next;
    hz_state_t            state_reg;
    hz_state_t            state_next;
    logic [WAIT_W-1:0]    wait_cnt_reg;
    logic [WAIT_W-1:0]    wait_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_sel_calc #(.AW(AW)) u_calc (
                .src          (id_src[gi*AW +: AW]),
                .used         (id_src_used[gi]),
                .ex_regwrite  (ex_regwrite),
                .ex_rd        (ex_rd),
                .mem_regwrite (mem_regwrite),
                .mem_rd       (mem_rd),
                .sel          (fwd_pre[gi*2 +: 2])
            );
            assign lu_hit[gi] = id_src_used[gi] & (id_src[gi*AW +: AW] == ex_rd);
        end
    endgenerate

    // Stall decisions are gated by rst_n so reset presents a free-running pipe.
    assign freeze      = rst_n & mem_req & ~mem_ready;
    assign lu          = rst_n & ~freeze & ex_memread & (ex_rd != '0) & (|lu_hit);
    assign pc_write    = ~(freeze | lu);
    assign ifid_write  = ~(freeze | lu);
    assign idex_bubble = lu;

    assign fwd_sel       = fwd_sel_reg;
    assign lu_stall_cnt  = lu_cnt_reg;
    assign mem_stall_cnt = mem_cnt_reg;
    assign mem_timeout   = timeout_reg;

    // Forward-select register: hold on freeze, clear for a bubble, else load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_sel_reg <= '0;
        end else if (freeze) begin
            fwd_sel_reg <= fwd_sel_reg;
        end else if (lu) begin
            fwd_sel_reg <= '0;
        end else begin
            fwd_sel_reg <= fwd_pre;
        end
    end

    // Saturating stall event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt_reg  <= '0;
            mem_cnt_reg <= '0;
        end else begin
            if (lu && (lu_cnt_reg != CNT_MAX)) begin
                lu_cnt_reg <= lu_cnt_reg + 1'b1;
            end
            if (freeze && (mem_cnt_reg != CNT_MAX)) begin
                mem_cnt_reg <= mem_cnt_reg + 1'b1;
            end
        end
    end

    // Memory-wait FSM state, wait counter and sticky timeout register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Memory-wait FSM next state; timeout sets when the count reaches the limit.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (freeze) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    if (wait_cnt_reg != WAIT_MAX) begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
        timeout_next = timeout_reg | (wait_cnt_next == WAIT_MAX);
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: a vector table for the forward
// selects and load-use detection, plus sequences for freeze, timeout and reset.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic        mem_req;
    logic        mem_ready;

    logic        pc_write, ifid_write, idex_bubble, freeze, mem_timeout;
    logic [3:0]  fwd_sel;
    logic [15:0] lu_stall_cnt, mem_stall_cnt;

    logic        s_pc_write, s_ifid_write, s_idex_bubble, s_freeze, s_mem_timeout;
    logic [3:0]  s_fwd_sel;
    logic [1:0]  s_lu_stall_cnt, s_mem_stall_cnt;

    int checks;
    int failures;

    hazard_fwd_ctrl #(.NUM_SRC(2), .AW(5), .CNT_W(16), .MEM_TIMEOUT(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .freeze(freeze), .fwd_sel(fwd_sel),
        .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
        .mem_timeout(mem_timeout)
    );

    hazard_fwd_ctrl #(.NUM_SRC(2), .AW(5), .CNT_W(2), .MEM_TIMEOUT(4)) u_small (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_bubble(s_idex_bubble), .freeze(s_freeze), .fwd_sel(s_fwd_sel),
        .lu_stall_cnt(s_lu_stall_cnt), .mem_stall_cnt(s_mem_stall_cnt),
        .mem_timeout(s_mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] src;
        logic [1:0] used;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] ex_rd;
        logic       mem_rw;
        logic [4:0] mem_rd;
        logic [3:0] exp_fwd;
        logic       exp_bub;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [4:0] s1, input logic [4:0] s0,
                                input logic [1:0] used, input logic ex_rw,
                                input logic ex_mr, input logic [4:0] erd,
                                input logic mem_rw, input logic [4:0] mrd,
                                input logic [3:0] exp_fwd, input logic exp_bub);
        vec_t v;
        v.src     = {s1, s0};
        v.used    = used;
        v.ex_rw   = ex_rw;
        v.ex_mr   = ex_mr;
        v.ex_rd   = erd;
        v.mem_rw  = mem_rw;
        v.mem_rd  = mrd;
        v.exp_fwd = exp_fwd;
        v.exp_bub = exp_bub;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_src       = '0;
        id_src_used  = '0;
        ex_regwrite  = 1'b0;
        ex_memread   = 1'b0;
        ex_rd        = '0;
        mem_regwrite = 1'b0;
        mem_rd       = '0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Load r2 in EX, dependent instruction in ID reading r2 as source 1.
    task automatic load_use_setup();
        idle_inputs();
        ex_regwrite = 1'b1;
        ex_memread  = 1'b1;
        ex_rd       = 5'd2;
        id_src      = {5'd2, 5'd0};
        id_src_used = 2'b10;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;

        vecs[0]  = mk(5'd0, 5'd1, 2'b01, 1, 0, 5'd1, 0, 5'd0, 4'b0010, 0);
        vecs[1]  = mk(5'd3, 5'd5, 2'b11, 1, 0, 5'd3, 1, 5'd3, 4'b1000, 0);
        vecs[2]  = mk(5'd0, 5'd0, 2'b11, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 0);
        vecs[3]  = mk(5'd7, 5'd7, 2'b01, 0, 0, 5'd0, 1, 5'd7, 4'b0001, 0);
        vecs[4]  = mk(5'd4, 5'd9, 2'b11, 1, 0, 5'd4, 1, 5'd9, 4'b1001, 0);
        vecs[5]  = mk(5'd0, 5'd4, 2'b10, 1, 0, 5'd4, 0, 5'd0, 4'b0000, 0);
        vecs[6]  = mk(5'd0, 5'd6, 2'b01, 0, 0, 5'd6, 1, 5'd6, 4'b0001, 0);
        vecs[7]  = mk(5'd2, 5'd0, 2'b01, 1, 1, 5'd2, 0, 5'd0, 4'b0000, 0);
        vecs[8]  = mk(5'd0, 5'd0, 2'b11, 0, 0, 5'd0, 1, 5'd0, 4'b0000, 0);
        vecs[9]  = mk(5'd0, 5'd5, 2'b01, 1, 1, 5'd5, 0, 5'd0, 4'b0000, 1);
        vecs[10] = mk(5'd0, 5'd0, 2'b11, 1, 1, 5'd0, 0, 5'd0, 4'b0000, 0);

        // Reset with a freeze and a load-use pending: combinational outputs forced.
        load_use_setup();
        mem_req = 1'b1;
        #2;
        chk("rst_freeze", freeze, 0);
        chk("rst_bubble", idex_bubble, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        step();
        chk("rst_fwd_sel", fwd_sel, 0);
        chk("rst_lu_cnt", lu_stall_cnt, 0);
        chk("rst_mem_cnt", mem_stall_cnt, 0);
        chk("rst_timeout", mem_timeout, 0);
        rst_n = 1'b1;
        idle_inputs();

        // Table: forward selects and single-cycle load-use detection.
        for (int i = 0; i < 11; i++) begin
            id_src       = vecs[i].src;
            id_src_used  = vecs[i].used;
            ex_regwrite  = vecs[i].ex_rw;
            ex_memread   = vecs[i].ex_mr;
            ex_rd        = vecs[i].ex_rd;
            mem_regwrite = vecs[i].mem_rw;
            mem_rd       = vecs[i].mem_rd;
            #1;
            chk($sformatf("vec%0d_bubble", i), idex_bubble, vecs[i].exp_bub);
            chk($sformatf("vec%0d_pc_write", i), pc_write, !vecs[i].exp_bub);
            chk($sformatf("vec%0d_ifid_write", i), ifid_write, !vecs[i].exp_bub);
            chk($sformatf("vec%0d_freeze", i), freeze, 0);
            step();
            chk($sformatf("vec%0d_fwd_sel", i), fwd_sel, vecs[i].exp_fwd);
            $display("vec %0d: fwd_sel=%b bubble_exp=%0b", i, fwd_sel, vecs[i].exp_bub);
        end
        chk("table_lu_cnt", lu_stall_cnt, 1);
        chk("table_mem_cnt", mem_stall_cnt, 0);

        // Load-use: one bubble, then the load forwards from MEM/WB.
        do_reset();
        load_use_setup();
        #1;
        chk("lu_bubble", idex_bubble, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        step();
        chk("lu_fwd_sel", fwd_sel, 4'b0000);
        chk("lu_cnt", lu_stall_cnt, 1);
        ex_regwrite  = 1'b0;
        ex_memread   = 1'b0;
        ex_rd        = '0;
        mem_regwrite = 1'b1;
        mem_rd       = 5'd2;
        #1;
        chk("lu_after_bubble", idex_bubble, 0);
        chk("lu_after_pc_write", pc_write, 1);
        step();
        chk("lu_after_fwd_sel", fwd_sel, 4'b0100);
        chk("lu_after_cnt", lu_stall_cnt, 1);
        $display("load-use seq: fwd_sel=%b lu_stall_cnt=%0d", fwd_sel, lu_stall_cnt);

        // Freeze over a load-use: fwd_sel held, no bubble, only memory stalls counted.
        do_reset();
        idle_inputs();
        ex_regwrite = 1'b1;
        ex_rd       = 5'd1;
        id_src      = {5'd0, 5'd1};
        id_src_used = 2'b01;
        step();
        chk("frz_pre_fwd", fwd_sel, 4'b0010);
        load_use_setup();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("frz%0d_freeze", c), freeze, 1);
            chk($sformatf("frz%0d_bubble", c), idex_bubble, 0);
            chk($sformatf("frz%0d_pc_write", c), pc_write, 0);
            step();
            chk($sformatf("frz%0d_fwd_sel", c), fwd_sel, 4'b0010);
        end
        chk("frz_mem_cnt", mem_stall_cnt, 3);
        chk("frz_lu_cnt", lu_stall_cnt, 0);
        chk("frz_timeout_small", s_mem_timeout, 0);
        mem_ready = 1'b1;
        #1;
        chk("frz_release_freeze", freeze, 0);
        chk("frz_release_bubble", idex_bubble, 1);
        step();
        chk("frz_release_fwd", fwd_sel, 4'b0000);
        $display("freeze seq: mem_stall_cnt=%0d lu_stall_cnt=%0d", mem_stall_cnt, lu_stall_cnt);

        // Timeout on the small instance: sets on the 4th freeze edge, sticky.
        do_reset();
        idle_inputs();
        mem_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("to_edge%0d_timeout", c), s_mem_timeout, (c >= 4) ? 1 : 0);
        end
        chk("to_mem_cnt_sat", s_mem_stall_cnt, 3);
        chk("to_default_timeout", mem_timeout, 0);
        mem_ready = 1'b1;
        step();
        chk("to_sticky", s_mem_timeout, 1);
        chk("to_sticky_cnt", s_mem_stall_cnt, 3);
        $display("timeout seq: s_mem_timeout=%0b s_mem_stall_cnt=%0d", s_mem_timeout, s_mem_stall_cnt);

        // Reset in the middle of a wait abandons it; count restarts from zero.
        mem_ready = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("to_rst_timeout", s_mem_timeout, 0);
        chk("to_rst_cnt", s_mem_stall_cnt, 0);
        chk("to_rst_fwd", s_fwd_sel, 0);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("to_re_edge%0d", c), s_mem_timeout, (c == 4) ? 1 : 0);
        end

        // Load-use counter saturation on the 2-bit instance.
        do_reset();
        load_use_setup();
        for (int c = 0; c < 4; c++) begin
            step();
        end
        chk("lu_cnt_sat", s_lu_stall_cnt, 3);
        chk("lu_cnt_wide", lu_stall_cnt, 4);
        $display("lu saturation: s_lu_stall_cnt=%0d lu_stall_cnt=%0d", s_lu_stall_cnt, lu_stall_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
